// File: rtl/gram_banked.sv
`default_nettype none
// ============================================================================
// Module   : gram_banked
// Purpose  : Banked general-purpose work RAM. A fixed bank 0 window sits at
//            START_ADDR and a switchable window directly above it maps to one
//            of banks 1..NUM_BANKS-1, chosen through a memory-mapped bank
//            select register at BANK_SEL_ADDR. Reads take one cycle and are
//            qualified with valid/hit flags; writes commit at the clock edge.
// Ports    : clk      - clock, all logic on the rising edge
//            reset    - synchronous, active-low reset
//            rd_en    - read request this cycle
//            rd_addr  - 16-bit read address
//            rd_data  - registered read data
//            rd_valid - rd_data valid, one cycle after rd_en
//            rd_hit   - address decoded to RAM or to the bank register
//            wr_en    - write strobe
//            wr_addr  - 16-bit write address
//            wr_data  - write data
//            bank_sel - current switchable bank, for debug/trace
// Config   : GRAM_ECHO_EN - when defined, the region from START_ADDR+2*BANK_SIZE
//            up to START_ADDR+4*BANK_SIZE-513 aliases the two RAM windows for
//            reads and writes. When undefined that region is undecoded.
// Revision : 1.0 - initial release
// ============================================================================
module gram_banked #(
  parameter int          DATA_W        = 8,
  parameter logic [15:0] START_ADDR    = 16'hC000,
  parameter logic [15:0] BANK_SIZE     = 16'h1000,
  parameter int          NUM_BANKS     = 8,
  parameter logic [15:0] BANK_SEL_ADDR = 16'hFF70,
  localparam int         BANK_W        = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [15:0]       rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_hit,
  input  logic              wr_en,
  input  logic [15:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [BANK_W-1:0] bank_sel
);

  // BANK_SIZE is a power of two, so bank*BANK_SIZE + offset is simply the
  // bank number concatenated above the in-bank offset; the result can never
  // exceed the physical array, so no wrap is possible.
  localparam int OFF_W     = $clog2(int'(BANK_SIZE));
  localparam int MEM_AW    = BANK_W + OFF_W;
  localparam int MEM_DEPTH = NUM_BANKS * int'(BANK_SIZE);

  // Window bounds held in 17 bits so the top of the map never wraps to zero.
  localparam logic [16:0] BS17   = {1'b0, BANK_SIZE};
  localparam logic [16:0] W0_LO  = {1'b0, START_ADDR};
  localparam logic [16:0] W1_LO  = W0_LO + BS17;
  localparam logic [16:0] W1_END = W0_LO + (BS17 << 1);
`ifdef GRAM_ECHO_EN
  localparam logic [16:0] E_LO   = W1_END;
  localparam logic [16:0] E_HI   = W0_LO + (BS17 << 2) - 17'd513;
`endif

  typedef struct packed {
    logic              ram;
    logic              breg;
    logic [MEM_AW-1:0] idx;
  } dec_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  dec_t              rd_dec;
  dec_t              wr_dec;
  logic [DATA_W-1:0] reg_val;
  logic [BANK_W-1:0] bank_next;

  function automatic dec_t decode(input logic [15:0] addr,
                                  input logic [BANK_W-1:0] bsel);
    dec_t        d;
    logic [16:0] a;
    d = '0;
    a = {1'b0, addr};
    if (addr == BANK_SEL_ADDR) begin
      d.breg = 1'b1;
    end else begin
`ifdef GRAM_ECHO_EN
      // Echo region folds down onto the two real windows.
      if (a >= E_LO && a <= E_HI) begin
        a = a - (BS17 << 1);
      end
`endif
      if (a >= W0_LO && a < W1_LO) begin
        d.ram = 1'b1;
        d.idx = {BANK_W'(0), OFF_W'(a - W0_LO)};
      end else if (a >= W1_LO && a < W1_END) begin
        d.ram = 1'b1;
        d.idx = {bsel, OFF_W'(a - W1_LO)};
      end
    end
    return d;
  endfunction

  // Both ports decode against the bank_sel value from before this edge, so a
  // same-cycle bank switch only affects later accesses.
  always_comb begin
    rd_dec = decode(rd_addr, bank_sel);
    wr_dec = decode(wr_addr, bank_sel);
  end

  // Bank register readback: upper bits read as ones, bank in the low bits.
  always_comb begin
    reg_val               = '1;
    reg_val[BANK_W-1:0]   = bank_sel;
  end

  // Bank 0 is permanently mapped low, so selecting it maps bank 1 instead.
  always_comb begin
    bank_next = wr_data[BANK_W-1:0];
    if (bank_next == '0) begin
      bank_next = BANK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      bank_sel <= BANK_W'(1);
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_hit <= rd_dec.ram | rd_dec.breg;
        if (rd_dec.breg) begin
          rd_data <= reg_val;
        end else if (rd_dec.ram) begin
          rd_data <= mem[rd_dec.idx];
        end else begin
          rd_data <= '1;
        end
      end
      if (wr_en && wr_dec.breg) begin
        bank_sel <= bank_next;
      end
    end
  end

  // RAM array has no reset; contents survive reset, but writes during a
  // reset cycle are suppressed. The read above samples the pre-edge value,
  // giving read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset && wr_en && wr_dec.ram) begin
      mem[wr_dec.idx] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gram_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_gram_banked
// Purpose  : Directed self-checking bench for gram_banked with default
//            parameters (8-bit data, 8 banks, windows at C000/D000, bank
//            register at FF70). Honours GRAM_ECHO_EN for the echo checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gram_banked;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_hit;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [2:0]  bank_sel;

  int asserts = 0;
  int fails   = 0;

  gram_banked dut (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_hit   (rd_hit),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .bank_sel (bank_sel)
  );

  always #5 clk = ~clk;

  // One clock with the given port values; outputs sampled 1 time unit after
  // the edge, so they show the result of the read issued in this step.
  task automatic step(input logic re, input logic [15:0] ra,
                      input logic we, input logic [15:0] wa,
                      input logic [7:0] wd);
    rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    step(1'b0, 16'h0000, 1'b1, a, d);
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b1, a, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) step(1'b0, 16'h0, 1'b0, 16'h0, 8'h0);
    reset = 1'b1;
    wr(16'hC020, 8'h44);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'hC020, 1'b1, (i == 1) ? 16'hFF70 : 16'hC020, 8'h99);
      asserts++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid cyc%0d: got %b want 0", i, rd_valid); end
      asserts++; if (rd_data !== 8'h00) begin fails++; $display("FAIL reset_data cyc%0d: got %h want 00", i, rd_data); end
      asserts++; if (bank_sel !== 3'd1) begin fails++; $display("FAIL reset_bank cyc%0d: got %0d want 1", i, bank_sel); end
    end
    reset = 1'b1;
    step(1'b0, 16'h0, 1'b0, 16'h0, 8'h0);
    asserts++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b want 0", rd_valid); end
    rd(16'hC020);
    asserts++; if (rd_data !== 8'h44) begin fails++; $display("FAIL reset_ram_kept: got %h want 44", rd_data); end
  endtask

  task automatic test_basic_rw;
    wr(16'hC000, 8'h5A);
    rd(16'hC000);
    asserts++; if (rd_data !== 8'h5A) begin fails++; $display("FAIL basic_data: got %h want 5a", rd_data); end
    asserts++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", rd_valid); end
    asserts++; if (rd_hit !== 1'b1) begin fails++; $display("FAIL basic_hit: got %b want 1", rd_hit); end
    step(1'b0, 16'h0, 1'b0, 16'h0, 8'h0);
    asserts++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", rd_valid); end
    asserts++; if (rd_data !== 8'h5A) begin fails++; $display("FAIL idle_hold: got %h want 5a", rd_data); end
    wr(16'hCFFF, 8'h3C);
    rd(16'hCFFF);
    asserts++; if (rd_data !== 8'h3C) begin fails++; $display("FAIL w0_top: got %h want 3c", rd_data); end
  endtask

  task automatic test_banking;
    wr(16'hFF70, 8'h03);
    asserts++; if (bank_sel !== 3'd3) begin fails++; $display("FAIL bank3: got %0d want 3", bank_sel); end
    wr(16'hD000, 8'h11);
    wr(16'hFF70, 8'h05);
    wr(16'hD000, 8'h22);
    wr(16'hFF70, 8'h03);
    rd(16'hD000);
    asserts++; if (rd_data !== 8'h11) begin fails++; $display("FAIL bank3_data: got %h want 11", rd_data); end
    wr(16'hFF70, 8'h05);
    rd(16'hD000);
    asserts++; if (rd_data !== 8'h22) begin fails++; $display("FAIL bank5_data: got %h want 22", rd_data); end
    rd(16'hC000);
    asserts++; if (rd_data !== 8'h5A) begin fails++; $display("FAIL bank0_kept: got %h want 5a", rd_data); end
  endtask

  task automatic test_bank_reg;
    wr(16'hFF70, 8'h00);
    asserts++; if (bank_sel !== 3'd1) begin fails++; $display("FAIL bank_zero: got %0d want 1", bank_sel); end
    rd(16'hFF70);
    asserts++; if (rd_data !== 8'hF9) begin fails++; $display("FAIL reg_read1: got %h want f9", rd_data); end
    asserts++; if (rd_hit !== 1'b1) begin fails++; $display("FAIL reg_hit: got %b want 1", rd_hit); end
    wr(16'hFF70, 8'hFF);
    asserts++; if (bank_sel !== 3'd7) begin fails++; $display("FAIL bank_ff: got %0d want 7", bank_sel); end
    rd(16'hFF70);
    asserts++; if (rd_data !== 8'hFF) begin fails++; $display("FAIL reg_read7: got %h want ff", rd_data); end
  endtask

  task automatic test_collisions;
    wr(16'hC010, 8'h01);
    step(1'b1, 16'hC010, 1'b1, 16'hC010, 8'hAA);
    asserts++; if (rd_data !== 8'h01) begin fails++; $display("FAIL read_first: got %h want 01", rd_data); end
    rd(16'hC010);
    asserts++; if (rd_data !== 8'hAA) begin fails++; $display("FAIL after_collide: got %h want aa", rd_data); end
    // bank_sel is 7 here
    wr(16'hD000, 8'h7E);
    wr(16'hFF70, 8'h02);
    wr(16'hD000, 8'h2B);
    wr(16'hFF70, 8'h07);
    step(1'b1, 16'hD000, 1'b1, 16'hFF70, 8'h02);
    asserts++; if (rd_data !== 8'h7E) begin fails++; $display("FAIL old_bank_read: got %h want 7e", rd_data); end
    asserts++; if (bank_sel !== 3'd2) begin fails++; $display("FAIL bank_switch: got %0d want 2", bank_sel); end
    rd(16'hD000);
    asserts++; if (rd_data !== 8'h2B) begin fails++; $display("FAIL new_bank_read: got %h want 2b", rd_data); end
  endtask

  task automatic test_echo_unmapped;
    wr(16'hC005, 8'h15);
    wr(16'hE005, 8'h77);
    rd(16'hE005);
`ifdef GRAM_ECHO_EN
    asserts++; if (rd_data !== 8'h77) begin fails++; $display("FAIL echo_data: got %h want 77", rd_data); end
    asserts++; if (rd_hit !== 1'b1) begin fails++; $display("FAIL echo_hit: got %b want 1", rd_hit); end
    rd(16'hC005);
    asserts++; if (rd_data !== 8'h77) begin fails++; $display("FAIL echo_alias: got %h want 77", rd_data); end
`else
    asserts++; if (rd_data !== 8'hFF) begin fails++; $display("FAIL echo_data: got %h want ff", rd_data); end
    asserts++; if (rd_hit !== 1'b0) begin fails++; $display("FAIL echo_hit: got %b want 0", rd_hit); end
    rd(16'hC005);
    asserts++; if (rd_data !== 8'h15) begin fails++; $display("FAIL echo_alias: got %h want 15", rd_data); end
`endif
    rd(16'h8000);
    asserts++; if (rd_data !== 8'hFF) begin fails++; $display("FAIL unmapped_data: got %h want ff", rd_data); end
    asserts++; if (rd_hit !== 1'b0) begin fails++; $display("FAIL unmapped_hit: got %b want 0", rd_hit); end
    asserts++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL unmapped_valid: got %b want 1", rd_valid); end
    rd(16'hFE00);
    asserts++; if (rd_hit !== 1'b0) begin fails++; $display("FAIL above_echo_hit: got %b want 0", rd_hit); end
  endtask

  initial begin
    test_reset;
    test_basic_rw;
    test_banking;
    test_bank_reg;
    test_collisions;
    test_echo_unmapped;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
